// File: rtl/uart_tx_pkg.sv
// Shared UART TX state definitions: the original controller states and the
// parametrised-transmitter states, plus parity-mode encodings.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SHIFT
  } TX_state_type;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } TX_param_state_type;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; dout shows the head word while
// the FIFO is not empty, and all status is derived from registered pointers.
module tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// FIFO-fed UART transmitter: 5..9 data bits, runtime parity and stop-bit
// selection, frames sent back-to-back on the external bit tick.
module uart_tx_fifo_param
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        TX_clock_enable,
  input  logic                        Write,
  input  logic [DATA_WIDTH-1:0]       TX_data,
  input  logic [1:0]                  Parity_mode,
  input  logic                        Two_stop,
  output logic                        Full,
  output logic                        Empty,
  output logic [$clog2(FIFO_DEPTH):0] Fill_level,
  output logic                        Busy,
  output logic                        Overflow,
  output logic                        UART_TX_O
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  TX_param_state_type    state_q, state_d;
  logic [DATA_WIDTH-1:0] buffer_q, buffer_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  parity_en_q, parity_en_d;
  logic                  parity_bit_q, parity_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  busy_q;
  logic                  overflow_q;
  logic                  pop;
  logic                  load;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  tx_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (Write),
    .pop   (pop),
    .din   (TX_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (Fill_level)
  );

  always_comb begin
    state_d      = state_q;
    buffer_d     = buffer_q;
    count_d      = count_q;
    stop_cnt_d   = stop_cnt_q;
    parity_en_d  = parity_en_q;
    parity_bit_d = parity_bit_q;
    two_stop_d   = two_stop_q;
    tx_d         = tx_q;
    load         = 1'b0;
    if (TX_clock_enable) begin
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          if (!fifo_empty) load = 1'b1;
        end
        S_START: begin
          tx_d    = 1'b0;
          count_d = '0;
          state_d = S_DATA;
        end
        S_DATA: begin
          tx_d       = buffer_q[count_q];
          stop_cnt_d = 1'b0;
          if (count_q < LAST_BIT) count_d = count_q + CW'(1);
          else                    state_d = parity_en_q ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          tx_d    = parity_bit_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          tx_d = 1'b1;
          if (two_stop_q && !stop_cnt_q) stop_cnt_d = 1'b1;
          else if (!fifo_empty)          load = 1'b1;
          else                           state_d = S_IDLE;
        end
        default: begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
    // Frame settings are captured with the word so later input changes
    // only affect the next popped frame.
    if (load) begin
      state_d      = S_START;
      buffer_d     = fifo_dout;
      parity_en_d  = parity_enabled(Parity_mode);
      parity_bit_d = (^fifo_dout) ^ (Parity_mode == PARITY_ODD);
      two_stop_d   = Two_stop;
    end
  end

  assign pop = load;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      buffer_q     <= '0;
      count_q      <= '0;
      stop_cnt_q   <= 1'b0;
      parity_en_q  <= 1'b0;
      parity_bit_q <= 1'b0;
      two_stop_q   <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buffer_q     <= buffer_d;
      count_q      <= count_d;
      stop_cnt_q   <= stop_cnt_d;
      parity_en_q  <= parity_en_d;
      parity_bit_q <= parity_bit_d;
      two_stop_q   <= two_stop_d;
      tx_q         <= tx_d;
      busy_q       <= (state_d != S_IDLE);
      overflow_q   <= Write && fifo_full;
    end
  end

  assign Full      = fifo_full;
  assign Empty     = fifo_empty;
  assign Busy      = busy_q;
  assign Overflow  = overflow_q;
  assign UART_TX_O = tx_q;

endmodule

// File: doc/uart_tx_fifo_param.md
# uart_tx_fifo_param

Parametrised UART transmitter for the lab designs: accepts words over a write/full handshake into an internal FIFO and serialises each one onto the UART TX pin. Frame format is selectable: 5–9 data bits (parameter), none/even/odd parity and 1 or 2 stop bits (runtime). Bit timing comes from an external one-cycle-per-bit enable from the existing baud generator. Successive frames go out back-to-back with no idle bit between them.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4: FIFO entries; power of two, 2..16.
- Clock  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- TX_clock_enable  input  1  one-cycle bit tick; every line change happens on a tick.
- Write  input  1  push TX_data into the FIFO this cycle.
- TX_data  input  DATA_WIDTH  word to send; LSB goes out first.
- Parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
- Two_stop  input  1  0: one stop bit, 1: two stop bits.
- Full  output  1  FIFO holds FIFO_DEPTH words.
- Empty  output  1  FIFO holds 0 words.
- Fill_level  output  $clog2(FIFO_DEPTH)+1  number of words in the FIFO.
- Busy  output  1  serialiser is not in S_IDLE.
- Overflow  output  1  one-cycle pulse when Write is rejected.
- UART_TX_O  output  1  serial line; idles high.

## Operation
- FIFO write side:
  - Write && !Full pushes TX_data.
  - Write && Full drops the word and pulses Overflow in the next cycle.
- FIFO read side:
  - The serialiser pops only on a tick, and only when FIFO is non-empty.
  - A push and a pop in the same cycle are both honoured; Fill_level is unchanged.
  - No bypass: a word written into an empty FIFO can be popped no earlier than the cycle after it is written.
- On pop:
  - The word goes into a shift buffer.
  - Parity_mode and Two_stop are latched into frame registers; mid-frame changes to these inputs have no effect.
- State machine; each state below is evaluated only on a tick:
  - S_IDLE: drive 1. If FIFO non-empty, pop and go to S_START.
  - S_START: drive 0 and clear the bit counter; go to S_DATA.
  - S_DATA: drive buffer[count].
    - If count < DATA_WIDTH-1, increment count.
    - Otherwise go to S_PARITY if parity is enabled, else S_STOP.
  - S_PARITY: drive the parity bit; go to S_STOP.
    - Even parity bit = XOR of the data bits.
    - Odd parity bit = the inverse of that.
  - S_STOP: drive 1. The stop-bit counter tracks 1 or 2 ticks.
    - On the last stop tick, if FIFO non-empty, pop and go to S_START; otherwise go to S_IDLE.
  - Any undefined state encoding: go to S_IDLE and drive 1.
- Busy = (state != S_IDLE), registered together with the state.

## Timing
- Reset values, taking effect on the first rising edge with Reset high:
  - UART_TX_O=1, Full=0, Empty=1, Fill_level=0, Busy=0, Overflow=0.
  - state=S_IDLE; FIFO pointers and counters = 0.
- Reset asserted mid-frame:
  - The frame is aborted and the FIFO is flushed.
  - The line is high from the next cycle.
  - Reset overrides Write and ticks in that cycle.
- UART_TX_O is a register and changes only in the cycle after a tick.
- Full, Empty and Fill_level are registered and reflect a push or pop one cycle after it.
- Latency, Write to start bit:
  - From S_IDLE: the pop happens on the first tick at least one cycle after the Write.
  - The start bit appears on the line after the following tick.
- Frame length in ticks: 1 + DATA_WIDTH + (parity ? 1 : 0) + (Two_stop ? 2 : 1).
- Back-to-back frames: the next start bit directly follows the last stop bit with no extra idle tick.
- Full FIFO with a pop in the same cycle: Write is still rejected, because Full is registered.
- Ticks while in S_IDLE with an empty FIFO: the line stays high and nothing changes.

## Structure
- Shared package uart_tx_pkg:
  - TX_param_state_type enum: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP.
  - Parity-mode localparams PARITY_NONE, PARITY_EVEN, PARITY_ODD.
  - This enum lives alongside the existing TX controller state type in the project's shared state definitions.
- Sub-module tx_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: Clock, Reset, push, pop, din, dout, full, empty, level.
  - Implementation: registered pointers with one extra wrap bit; dout valid while !empty.
- Top level holds the serialiser FSM, shift buffer, counters, parity register and Overflow logic.

## Test plan
- 8N1 (Parity_mode=00, Two_stop=0), Write 8'hA5 from reset, tick every 16 clocks:
  - Line after each tick: 0, 1,0,1,0,0,1,0,1, then 1.
  - Busy falls after the stop bit.
- DATA_WIDTH=7, even parity, Two_stop=1, word 7'h13:
  - Frame: 0, 1,1,0,0,1,0,0, parity 1, stop 1,1.
  - 11 ticks in total.
  - Repeat with odd parity: the parity bit is 0.
- Burst of 4 Writes (8'h01..8'h04) in 4 consecutive cycles with FIFO_DEPTH=4:
  - Full=1 after the fourth write.
  - A fifth Write pulses Overflow and that word is dropped.
  - Four frames go out back-to-back with no idle tick between them.
- Change Parity_mode from 00 to 10 in the middle of an 8N1 frame:
  - The current frame has no parity bit.
  - The next frame carries odd parity.
- Assert Reset during data bit 3:
  - Next cycle: UART_TX_O=1, Empty=1, Fill_level=0, Busy=0.
  - No further frame is sent.
- Write coinciding with a pop at Fill_level=2:
  - Fill_level stays 2.
  - Word order is preserved on the line.
